// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM request controller: state encoding and
// default data/address widths.
package ram_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 1;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage : ram_ctrl_pkg

// File: rtl/ram_ctrl_init_cnt.sv
// Saturating up-counter that walks the RAM word addresses during the
// post-clear zero sweep.
//   clk, clear : clock and asynchronous active-high clear (count -> 0)
//   en         : advance the count; holds once the last word is reached
//   cnt        : current word address (registered)
//   tc_c       : terminal count, cnt == DEPTH-1 (combinational)
module ram_ctrl_init_cnt #(
  parameter int unsigned ADDR_W = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              en,
  output logic [ADDR_W-1:0] cnt,
  output logic              tc_c
);

  // The last word address is all ones, so the sweep stops without wrapping.
  assign tc_c = &cnt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt <= '0;
    end else if (en && !tc_c) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

endmodule : ram_ctrl_init_cnt

// File: rtl/ram_ctrl.sv
// Request-side controller for the small JK-flip-flop RAM arrays. Serialises
// read/write requests onto the RAM addr/r_w/in pins one at a time, returns
// read data over a valid/ready response channel, and zero-fills every word
// after each clear.
//   clk, clear                       : clock, asynchronous active-high reset
//   req_valid/req_ready              : request handshake
//   req_write, req_addr, req_wdata   : request payload (1 = write)
//   rsp_valid/rsp_ready, rsp_data    : read response handshake and data
//   busy                             : controller is not in IDLE
//   mem_addr, mem_r_w, mem_in        : to RAM (r_w = 1 is a write strobe)
//   mem_out                          : from RAM
// Every output comes straight from a flop.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_r_w,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_r_w_q, mem_r_w_d;
  logic [DATA_W-1:0]   mem_in_q, mem_in_d;

  logic                cnt_en_c;
  logic [ADDR_W-1:0]   init_cnt;
  logic                init_tc_c;

  // Word address generator for the zero sweep.
  ram_ctrl_init_cnt #(
    .ADDR_W (ADDR_W)
  ) u_init_cnt (
    .clk   (clk),
    .clear (clear),
    .en    (cnt_en_c),
    .cnt   (init_cnt),
    .tc_c  (init_tc_c)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= ST_INIT;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b1;
      mem_addr_q  <= '0;
      mem_r_w_q   <= 1'b0;
      mem_in_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_r_w_q   <= mem_r_w_d;
      mem_in_q    <= mem_in_d;
    end
  end

  // Next state and next registered outputs; outputs line up with state_q.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    mem_addr_d  = mem_addr_q;
    mem_r_w_d   = mem_r_w_q;
    mem_in_d    = mem_in_q;
    cnt_en_c    = 1'b0;

    case (state_q)
      ST_INIT: begin
        // The counter saturates on the last word, so the last word is on the
        // bus exactly when the strobe is up and the bus address equals it.
        if (mem_r_w_q && init_tc_c && (mem_addr_q == init_cnt)) begin
          state_d     = ST_IDLE;
          mem_r_w_d   = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          mem_r_w_d  = 1'b1;
          mem_in_d   = '0;
          mem_addr_d = init_cnt;
          cnt_en_c   = 1'b1;
        end
      end

      ST_IDLE: begin
        mem_r_w_d = 1'b0;
        if (req_valid) begin
          req_ready_d = 1'b0;
          mem_addr_d  = req_addr;
          if (req_write) begin
            state_d   = ST_WRITE;
            mem_r_w_d = 1'b1;
            mem_in_d  = req_wdata;
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_WRITE: begin
        state_d     = ST_IDLE;
        mem_r_w_d   = 1'b0;
        req_ready_d = 1'b1;
      end

      ST_READ: begin
        state_d     = ST_RESP;
        rsp_data_d  = mem_out;
        rsp_valid_d = 1'b1;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_INIT;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        mem_r_w_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_r_w   = mem_r_w_q;
  assign mem_in    = mem_in_q;

endmodule : ram_ctrl

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl with a 2-word x 8-bit RAM model attached.
module tb_ram_ctrl;

  logic       clk;
  logic       clear;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [0:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;
  logic [0:0] mem_addr;
  logic       mem_r_w;
  logic [7:0] mem_in;
  logic [7:0] mem_out;

  int n_checks = 0;
  int n_fail   = 0;

  ram_ctrl #(
    .DATA_W (8),
    .ADDR_W (1)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_r_w   (mem_r_w),
    .mem_in    (mem_in),
    .mem_out   (mem_out)
  );

  // RAM model: synchronous write strobe, asynchronous read, no reset.
  logic [7:0] ram [2];
  initial begin
    ram[0] = 8'hA5;
    ram[1] = 8'h5A;
  end
  always @(posedge clk) if (mem_r_w) ram[mem_addr] <= mem_in;
  assign mem_out = ram[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ready: req_ready=%b, expected 1 within 20 cycles", req_ready);
    end
  endtask

  task automatic do_write(input logic [0:0] a, input logic [7:0] d);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    check("wr_strobe", 32'(mem_r_w), 32'd1);
    check("wr_addr", 32'(mem_addr), 32'(a));
    check("wr_data", 32'(mem_in), 32'(d));
    check("wr_ready_low", 32'(req_ready), 32'd0);
    check("wr_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("wr_ready_back", 32'(req_ready), 32'd1);
    check("wr_strobe_off", 32'(mem_r_w), 32'd0);
  endtask

  task automatic do_read(input logic [0:0] a, input logic [7:0] exp, input int stall);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rd_addr", 32'(mem_addr), 32'(a));
    check("rd_no_strobe", 32'(mem_r_w), 32'd0);
    check("rd_valid_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rd_valid", 32'(rsp_valid), 32'd1);
    check("rd_data", 32'(rsp_data), 32'(exp));
    check("rd_ready_low", 32'(req_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'(exp));
      check("bp_ready_low", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done_valid", 32'(rsp_valid), 32'd0);
    check("rsp_done_ready", 32'(req_ready), 32'd1);
    check("rsp_done_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic       wr;
    logic [0:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         stall;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{wr: 1'b0, addr: 1'b1, wdata: 8'h00, exp_rdata: 8'h00, stall: 0};
    vecs[1] = '{wr: 1'b1, addr: 1'b0, wdata: 8'h03, exp_rdata: 8'h00, stall: 0};
    vecs[2] = '{wr: 1'b1, addr: 1'b1, wdata: 8'h09, exp_rdata: 8'h00, stall: 0};
    vecs[3] = '{wr: 1'b0, addr: 1'b0, wdata: 8'h00, exp_rdata: 8'h03, stall: 0};
    vecs[4] = '{wr: 1'b0, addr: 1'b1, wdata: 8'h00, exp_rdata: 8'h09, stall: 0};
    vecs[5] = '{wr: 1'b0, addr: 1'b1, wdata: 8'h00, exp_rdata: 8'h09, stall: 5};

    clear = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 1'b0; req_wdata = 8'h00; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_strobe", 32'(mem_r_w), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_in", 32'(mem_in), 32'd0);
    clear = 1'b0;

    // Zero sweep: word 0 then word 1, then IDLE.
    @(negedge clk);
    check("init0_strobe", 32'(mem_r_w), 32'd1);
    check("init0_addr", 32'(mem_addr), 32'd0);
    check("init0_in", 32'(mem_in), 32'd0);
    check("init0_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("init1_strobe", 32'(mem_r_w), 32'd1);
    check("init1_addr", 32'(mem_addr), 32'd1);
    @(negedge clk);
    check("init_done_ready", 32'(req_ready), 32'd1);
    check("init_done_strobe", 32'(mem_r_w), 32'd0);
    check("init_done_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdata);
      else            do_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].stall);
    end

    // Back-to-back writes with req_valid held high: accepts 2 cycles apart.
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 1'b0; req_wdata = 8'h04;
    @(negedge clk);
    check("b2b_w0_strobe", 32'(mem_r_w), 32'd1);
    check("b2b_w0_in", 32'(mem_in), 32'h04);
    check("b2b_w0_ready", 32'(req_ready), 32'd0);
    req_addr = 1'b1; req_wdata = 8'h0A;
    @(negedge clk);
    check("b2b_idle_strobe", 32'(mem_r_w), 32'd0);
    check("b2b_idle_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_w1_strobe", 32'(mem_r_w), 32'd1);
    check("b2b_w1_addr", 32'(mem_addr), 32'd1);
    check("b2b_w1_in", 32'(mem_in), 32'h0A);
    do_read(1'b0, 8'h04, 0);
    do_read(1'b1, 8'h0A, 0);

    // Clear pulsed during READ: response discarded, sweep repeats.
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("clr_in_read", 32'(busy), 32'd1);
    #2 clear = 1'b1;
    #1;
    check("clr_async_busy", 32'(busy), 32'd1);
    check("clr_async_ready", 32'(req_ready), 32'd0);
    check("clr_async_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("clr_no_rsp", 32'(rsp_valid), 32'd0);
    // Requests and rsp_ready during INIT must be ignored.
    clear = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("reinit0_strobe", 32'(mem_r_w), 32'd1);
    check("reinit0_addr", 32'(mem_addr), 32'd0);
    check("reinit0_ready", 32'(req_ready), 32'd0);
    check("reinit0_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("reinit1_strobe", 32'(mem_r_w), 32'd1);
    check("reinit1_addr", 32'(mem_addr), 32'd1);
    check("reinit1_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
    @(negedge clk);
    check("reinit_idle_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("late_accept_busy", 32'(busy), 32'd1);
    check("late_accept_strobe", 32'(mem_r_w), 32'd0);
    check("late_accept_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    check("late_rsp_valid", 32'(rsp_valid), 32'd1);
    check("late_rsp_data", 32'(rsp_data), 32'h00);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("late_rsp_done", 32'(rsp_valid), 32'd0);
    do_read(1'b1, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ram_ctrl
